// File: rtl/btn_conditioner.sv
// Multi-channel pushbutton front end: synchroniser, debounce filter, edge-mode pulse
// and long-press event per channel, all gated by a power-up warmup window.
module btn_conditioner #(
    parameter int N_CH            = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int WARMUP_BITS     = 16,
    parameter int HOLD_CYCLES     = 12000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   btn_in,
    input  logic [2*N_CH-1:0] edge_sel,
    output logic [N_CH-1:0]   btn_level,
    output logic [N_CH-1:0]   btn_pulse,
    output logic [N_CH-1:0]   btn_long,
    output logic              armed
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
    localparam logic [WARMUP_BITS-1:0] WARM_ONE = WARMUP_BITS'(1);

    logic [WARMUP_BITS-1:0] warm_cnt;

    // Counter stops at all-ones, so armed stays high until the next reset.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            warm_cnt <= '0;
        end else if (!armed) begin
            warm_cnt <= warm_cnt + WARM_ONE;
        end
    end

    assign armed = &warm_cnt;

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   sync_out;
        logic [DB_W-1:0]        db_cnt, db_cnt_d;
        logic                   level_q, level_d, level_prev;
        logic                   rise, fall;
        logic [1:0]             sel;
        logic                   pulse_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in[ch]};
            end
        end

        assign sync_out = sync_q[SYNC_STAGES-1];

        // Any sample matching the accepted level restarts the count.
        always_comb begin
            // NOTE: every output gets a default first, so no path leaves it unassigned (no latch).
            db_cnt_d = '0;
            level_d  = level_q;
            if (sync_out != level_q) begin
                if (db_cnt == DB_LAST) begin
                    level_d = ~level_q;
                end else begin
                    db_cnt_d = db_cnt + DB_ONE;
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                db_cnt     <= '0;
                level_q    <= 1'b0;
                level_prev <= 1'b0;
            end else begin
                db_cnt     <= db_cnt_d;
                level_q    <= level_d;
                level_prev <= level_q;
            end
        end

        // Edges come from the debounced level, so a mode change alone never pulses.
        assign rise = level_q & ~level_prev;
        assign fall = ~level_q & level_prev;
        assign sel  = edge_sel[2*ch +: 2];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pulse_q <= 1'b0;
            end else begin
                pulse_q <= armed & ((rise & sel[0]) | (fall & sel[1]));
            end
        end

        assign btn_level[ch] = level_q;
        assign btn_pulse[ch] = pulse_q;

        if (HOLD_CYCLES > 0) begin : g_hold
            localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
            localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);
            localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
            localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

            logic [HOLD_W-1:0] hold_cnt, hold_d;
            logic              long_d, long_q;

            // Saturating at HOLD_MAX gives exactly one event per press.
            always_comb begin
                hold_d = hold_cnt;
                long_d = 1'b0;
                if (!level_q) begin
                    hold_d = '0;
                end else if (armed && hold_cnt != HOLD_MAX) begin
                    hold_d = hold_cnt + HOLD_ONE;
                    long_d = (hold_cnt == HOLD_LAST);
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    hold_cnt <= '0;
                    long_q   <= 1'b0;
                end else begin
                    hold_cnt <= hold_d;
                    long_q   <= long_d;
                end
            end

            assign btn_long[ch] = long_q;
        end else begin : g_no_hold
            assign btn_long[ch] = 1'b0;
        end
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner: a table of held-input vectors with expected
// outputs, plus hand-written reset sequences.
module tb_btn_conditioner;

    localparam int N_CH = 2;

    logic              clk;
    logic              rst;
    logic [N_CH-1:0]   btn_in;
    logic [2*N_CH-1:0] edge_sel;
    logic [N_CH-1:0]   btn_level, btn_pulse, btn_long;
    logic              armed;

    int n_cmp = 0;
    int n_bad = 0;

    btn_conditioner #(
        .N_CH(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .WARMUP_BITS(4), .HOLD_CYCLES(10)
    ) dut (
        .clk(clk), .rst(rst), .btn_in(btn_in), .edge_sel(edge_sel),
        .btn_level(btn_level), .btn_pulse(btn_pulse), .btn_long(btn_long), .armed(armed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs held for n edges; intermediate edges must show no events,
    // the last edge must show the expected level/pulse/long/armed.
    typedef struct {
        logic [1:0] btn;
        logic [3:0] sel;
        int         n;
        logic [1:0] lvl;
        logic [1:0] pls;
        logic [1:0] lng;
        logic       arm;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [1:0] btn, input logic [3:0] sel, input int n,
                                input logic [1:0] lvl, input logic [1:0] pls,
                                input logic [1:0] lng, input logic arm);
        vec_t v;
        v.btn = btn; v.sel = sel; v.n = n;
        v.lvl = lvl; v.pls = pls; v.lng = lng; v.arm = arm;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [6:0] act,
                         input logic [6:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s #%0d: got lvl/pls/lng/arm=%b, want %b", name, idx, act, exp);
        end
    endtask

    function automatic logic [6:0] outs();
        return {btn_level, btn_pulse, btn_long, armed};
    endfunction

    initial begin
        // warmup with ch0 held from release
        vecs.push_back(mk(2'b01, 4'b0101, 5, 2'b00, 2'b00, 2'b00, 1'b0));
        vecs.push_back(mk(2'b01, 4'b0101, 1, 2'b01, 2'b00, 2'b00, 1'b0));
        vecs.push_back(mk(2'b01, 4'b0101, 8, 2'b01, 2'b00, 2'b00, 1'b0));
        vecs.push_back(mk(2'b01, 4'b0101, 1, 2'b01, 2'b00, 2'b00, 1'b1));
        // press in progress counts from arming
        vecs.push_back(mk(2'b01, 4'b0101, 9, 2'b01, 2'b00, 2'b00, 1'b1));
        vecs.push_back(mk(2'b01, 4'b0101, 1, 2'b01, 2'b00, 2'b01, 1'b1));
        vecs.push_back(mk(2'b01, 4'b0101, 1, 2'b01, 2'b00, 2'b00, 1'b1));
        vecs.push_back(mk(2'b01, 4'b0101, 5, 2'b01, 2'b00, 2'b00, 1'b1));
        vecs.push_back(mk(2'b00, 4'b0101, 6, 2'b00, 2'b00, 2'b00, 1'b1));
        vecs.push_back(mk(2'b00, 4'b0101, 3, 2'b00, 2'b00, 2'b00, 1'b1));
        // rising mode press, then 30-cycle hold
        vecs.push_back(mk(2'b01, 4'b0101, 6, 2'b01, 2'b00, 2'b00, 1'b1));
        vecs.push_back(mk(2'b01, 4'b0101, 1, 2'b01, 2'b01, 2'b00, 1'b1));
        vecs.push_back(mk(2'b01, 4'b0101, 1, 2'b01, 2'b00, 2'b00, 1'b1));
        vecs.push_back(mk(2'b01, 4'b0101, 7, 2'b01, 2'b00, 2'b00, 1'b1));
        vecs.push_back(mk(2'b01, 4'b0101, 1, 2'b01, 2'b00, 2'b01, 1'b1));
        vecs.push_back(mk(2'b01, 4'b0101, 14, 2'b01, 2'b00, 2'b00, 1'b1));
        // release: no pulse in rising mode; re-press fires long again
        vecs.push_back(mk(2'b00, 4'b0101, 6, 2'b00, 2'b00, 2'b00, 1'b1));
        vecs.push_back(mk(2'b00, 4'b0101, 2, 2'b00, 2'b00, 2'b00, 1'b1));
        vecs.push_back(mk(2'b01, 4'b0101, 6, 2'b01, 2'b00, 2'b00, 1'b1));
        vecs.push_back(mk(2'b01, 4'b0101, 1, 2'b01, 2'b01, 2'b00, 1'b1));
        vecs.push_back(mk(2'b01, 4'b0101, 9, 2'b01, 2'b00, 2'b01, 1'b1));
        vecs.push_back(mk(2'b00, 4'b0101, 8, 2'b00, 2'b00, 2'b00, 1'b1));
        // ch1 bounce, both-edge mode
        vecs.push_back(mk(2'b10, 4'b1100, 3, 2'b00, 2'b00, 2'b00, 1'b1));
        vecs.push_back(mk(2'b00, 4'b1100, 2, 2'b00, 2'b00, 2'b00, 1'b1));
        vecs.push_back(mk(2'b10, 4'b1100, 6, 2'b10, 2'b00, 2'b00, 1'b1));
        vecs.push_back(mk(2'b10, 4'b1100, 1, 2'b10, 2'b10, 2'b00, 1'b1));
        vecs.push_back(mk(2'b10, 4'b1100, 1, 2'b10, 2'b00, 2'b00, 1'b1));
        vecs.push_back(mk(2'b00, 4'b1100, 6, 2'b00, 2'b00, 2'b00, 1'b1));
        vecs.push_back(mk(2'b00, 4'b1100, 1, 2'b00, 2'b10, 2'b00, 1'b1));
        vecs.push_back(mk(2'b00, 4'b1100, 2, 2'b00, 2'b00, 2'b00, 1'b1));
        // ch0 mode none, ch1 falling only, pressed together
        vecs.push_back(mk(2'b11, 4'b1000, 6, 2'b11, 2'b00, 2'b00, 1'b1));
        vecs.push_back(mk(2'b11, 4'b1000, 1, 2'b11, 2'b00, 2'b00, 1'b1));
        vecs.push_back(mk(2'b11, 4'b1000, 1, 2'b11, 2'b00, 2'b00, 1'b1));
        vecs.push_back(mk(2'b00, 4'b1000, 6, 2'b00, 2'b00, 2'b00, 1'b1));
        vecs.push_back(mk(2'b00, 4'b1000, 1, 2'b00, 2'b10, 2'b00, 1'b1));
        vecs.push_back(mk(2'b00, 4'b1000, 2, 2'b00, 2'b00, 2'b00, 1'b1));

        rst      = 1'b1;
        btn_in   = '0;
        edge_sel = 4'b0101;
        repeat (3) @(negedge clk);
        check("reset_state", 0, outs(), 7'b0);

        btn_in = 2'b01;
        rst    = 1'b0;
        foreach (vecs[i]) begin
            btn_in   = vecs[i].btn;
            edge_sel = vecs[i].sel;
            for (int k = 1; k <= vecs[i].n; k++) begin
                @(posedge clk);
                @(negedge clk);
                if (k < vecs[i].n)
                    check("quiet", i, {btn_pulse, btn_long, 3'b0}, 7'b0);
                else
                    check("vector", i, outs(),
                          {vecs[i].lvl, vecs[i].pls, vecs[i].lng, vecs[i].arm});
            end
        end

        // Reset while level is high, a pulse is out and the hold count is running
        btn_in   = 2'b01;
        edge_sel = 4'b0101;
        repeat (6) begin @(posedge clk); @(negedge clk); end
        check("mid_pre_level", 0, outs(), {2'b01, 2'b00, 2'b00, 1'b1});
        @(posedge clk); @(negedge clk);
        check("mid_pre_pulse", 0, outs(), {2'b01, 2'b01, 2'b00, 1'b1});
        rst = 1'b1;
        #1;
        check("mid_reset_async", 0, outs(), 7'b0);
        repeat (2) @(negedge clk);
        check("mid_reset_held", 0, outs(), 7'b0);
        rst = 1'b0;
        for (int e = 1; e <= 26; e++) begin
            @(posedge clk);
            @(negedge clk);
            check("rewarm", e, outs(),
                  {(e >= 6) ? 2'b01 : 2'b00, 2'b00, (e == 25) ? 2'b01 : 2'b00, e >= 15});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
